// File: rtl/intersection_master_timer_if.sv
// ----------------------------------------------------------------------------
// intersection_master_timer_if
//   Groups the pedestrian button input and all timing/light outputs of the
//   intersection master timer into one bundle.
//
//   Signals:
//     ped_request    pedestrian button (level or pulse)
//     master_timer   seconds remaining in the current phase (7 bits, unsigned)
//     ns_light       NS vehicle light, one-hot {red,yellow,green}
//     ew_light       EW vehicle light, one-hot {red,yellow,green}
//     ns_ped_enable  walk enable for the NS pedestrian_light
//     ew_ped_enable  walk enable for the EW pedestrian_light
//     sec_tick       one-cycle pulse per second
//
//   Modports:
//     master  the timer itself (drives everything except ped_request)
//     slave   the consumer side (pedestrian lights / button logic)
// ----------------------------------------------------------------------------
interface intersection_master_timer_if;
    logic       ped_request;
    logic [6:0] master_timer;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ns_ped_enable;
    logic       ew_ped_enable;
    logic       sec_tick;

    modport master (
        input  ped_request,
        output master_timer,
        output ns_light,
        output ew_light,
        output ns_ped_enable,
        output ew_ped_enable,
        output sec_tick
    );

    modport slave (
        output ped_request,
        input  master_timer,
        input  ns_light,
        input  ew_light,
        input  ns_ped_enable,
        input  ew_ped_enable,
        input  sec_tick
    );
endinterface

// File: rtl/intersection_master_timer.sv
// ----------------------------------------------------------------------------
// intersection_master_timer
//   Sequences a two-direction (NS / EW) intersection through green, yellow
//   and all-red phases using a one-second prescaler, publishes the seconds
//   remaining in the current phase, and grants pedestrian walk on the next
//   green after a button press.
//
//   Ports:
//     clk    system clock, everything on the rising edge
//     reset  synchronous, active-high
//     bus    intersection_master_timer_if.master (ped_request in; timer,
//            lights, ped enables and sec_tick out)
//
//   Optional feature (macro PED_EXTEND_EN):
//     defined   - a green entered with walk granted lasts PED_GREEN_TIME s
//     undefined - every green lasts GREEN_TIME s
// ----------------------------------------------------------------------------
module intersection_master_timer #(
    parameter int CLKS_PER_SEC   = 50,
    parameter int GREEN_TIME     = 60,
    parameter int YELLOW_TIME    = 5,
    parameter int ALLRED_TIME    = 2,
    parameter int PED_GREEN_TIME = 90
) (
    input  logic                            clk,
    input  logic                            reset,
    intersection_master_timer_if.master     bus
);

    localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(CLKS_PER_SEC - 2);

`ifdef PED_EXTEND_EN
    localparam int WALK_GREEN = PED_GREEN_TIME;
`else
    // Walk does not lengthen the green in this build.
    localparam int WALK_GREEN = GREEN_TIME + 0 * PED_GREEN_TIME;
`endif

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        ALLRED_A,
        NS_GREEN,
        NS_YELLOW,
        ALLRED_B,
        EW_GREEN,
        EW_YELLOW
    } phase_t;

    phase_t        phase;
    logic [PW-1:0] presc;
    logic [6:0]    timer;
    logic [2:0]    ns_l;
    logic [2:0]    ew_l;
    logic          ns_ped;
    logic          ew_ped;
    logic          tick;
    logic          req_latch;

    // A press in the very cycle a green is entered still counts for it.
    logic grant;
    assign grant = req_latch | bus.ped_request;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= ALLRED_A;
            presc     <= '0;
            timer     <= 7'(ALLRED_TIME);
            ns_l      <= RED;
            ew_l      <= RED;
            ns_ped    <= 1'b0;
            ew_ped    <= 1'b0;
            tick      <= 1'b0;
            req_latch <= 1'b0;
        end else begin
            presc     <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            // Registered so it is high exactly while presc sits at its last count.
            tick      <= (presc == PRESC_PRE);
            req_latch <= grant;

            if (presc == PRESC_LAST) begin
                if (timer > 7'd1) begin
                    timer <= timer - 7'd1;
                end else begin
                    // Timer shows 1 for the final second: advance and reload together.
                    case (phase)
                        ALLRED_A: begin
                            phase     <= NS_GREEN;
                            timer     <= grant ? 7'(WALK_GREEN) : 7'(GREEN_TIME);
                            ns_l      <= GRN;
                            ew_l      <= RED;
                            ns_ped    <= grant;
                            req_latch <= 1'b0;
                        end
                        NS_GREEN: begin
                            phase  <= NS_YELLOW;
                            timer  <= 7'(YELLOW_TIME);
                            ns_l   <= YEL;
                            ew_l   <= RED;
                            ns_ped <= 1'b0;
                        end
                        NS_YELLOW: begin
                            phase <= ALLRED_B;
                            timer <= 7'(ALLRED_TIME);
                            ns_l  <= RED;
                            ew_l  <= RED;
                        end
                        ALLRED_B: begin
                            phase     <= EW_GREEN;
                            timer     <= grant ? 7'(WALK_GREEN) : 7'(GREEN_TIME);
                            ns_l      <= RED;
                            ew_l      <= GRN;
                            ew_ped    <= grant;
                            req_latch <= 1'b0;
                        end
                        EW_GREEN: begin
                            phase  <= EW_YELLOW;
                            timer  <= 7'(YELLOW_TIME);
                            ns_l   <= RED;
                            ew_l   <= YEL;
                            ew_ped <= 1'b0;
                        end
                        EW_YELLOW: begin
                            phase <= ALLRED_A;
                            timer <= 7'(ALLRED_TIME);
                            ns_l  <= RED;
                            ew_l  <= RED;
                        end
                        default: begin
                            phase  <= ALLRED_A;
                            timer  <= 7'(ALLRED_TIME);
                            ns_l   <= RED;
                            ew_l   <= RED;
                            ns_ped <= 1'b0;
                            ew_ped <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.master_timer  = timer;
    assign bus.ns_light      = ns_l;
    assign bus.ew_light      = ew_l;
    assign bus.ns_ped_enable = ns_ped;
    assign bus.ew_ped_enable = ew_ped;
    assign bus.sec_tick      = tick;

endmodule

// File: tb/tb_intersection_master_timer.sv
// ----------------------------------------------------------------------------
// tb_intersection_master_timer
//   Directed bench for intersection_master_timer with CLKS_PER_SEC = 4.
//   Edge numbers count rising edges after reset release; outputs are
//   sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_intersection_master_timer;

    localparam int CPS = 4;
`ifdef PED_EXTEND_EN
    localparam int EXP_WALK = 90;
`else
    localparam int EXP_WALK = 60;
`endif

    logic clk = 1'b0;
    logic reset;
    int   edge_n;
    int   n_total;
    int   n_pass;

    always #5 clk = ~clk;

    intersection_master_timer_if bus ();

    intersection_master_timer #(
        .CLKS_PER_SEC  (CPS),
        .GREEN_TIME    (60),
        .YELLOW_TIME   (5),
        .ALLRED_TIME   (2),
        .PED_GREEN_TIME(90)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int         e;
        int         t;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       nsp;
        logic       ewp;
        logic       tick;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic adv_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, "_timer"}, int'(bus.master_timer), v.t);
        chk({tag, "_ns"},    int'(bus.ns_light), int'(v.ns));
        chk({tag, "_ew"},    int'(bus.ew_light), int'(v.ew));
        chk({tag, "_nsped"}, int'(bus.ns_ped_enable), int'(v.nsp));
        chk({tag, "_ewped"}, int'(bus.ew_ped_enable), int'(v.ewp));
        chk({tag, "_tick"},  int'(bus.sec_tick), int'(v.tick));
    endtask

    initial begin
        int ey, g1, e2, g2, e3;
        n_total = 0;
        n_pass  = 0;
        edge_n  = 0;

        // Free-run checkpoints: {edge, timer, ns, ew, ns_ped, ew_ped, tick}
        vec[0]  = '{0,   2,  3'b100, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{3,   2,  3'b100, 3'b100, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{4,   1,  3'b100, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{7,   1,  3'b100, 3'b100, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{8,   60, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{12,  59, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{247, 1,  3'b001, 3'b100, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{248, 5,  3'b010, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{267, 1,  3'b010, 3'b100, 1'b0, 1'b0, 1'b1};
        vec[9]  = '{268, 2,  3'b100, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[10] = '{276, 60, 3'b100, 3'b001, 1'b0, 1'b0, 1'b0};
        vec[11] = '{516, 5,  3'b100, 3'b010, 1'b0, 1'b0, 1'b0};
        vec[12] = '{536, 2,  3'b100, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[13] = '{540, 1,  3'b100, 3'b100, 1'b0, 1'b0, 1'b0};
        vec[14] = '{544, 60, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0};

        // Reset held for three edges, then released.
        reset = 1'b1;
        bus.ped_request = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset  = 1'b0;
        edge_n = 0;

        for (int i = 0; i < 15; i++) begin
            adv_to(vec[i].e);
            chk_all($sformatf("v%0d", i), vec[i]);
        end

        // One-cycle press during NS_YELLOW (entered at 784) -> walk on EW_GREEN.
        adv_to(790);
        bus.ped_request = 1'b1;
        step();
        bus.ped_request = 1'b0;
        chk("yel_press_nsped", int'(bus.ns_ped_enable), 0);
        adv_to(811);
        chk("allred_b_ewped", int'(bus.ew_ped_enable), 0);
        chk("allred_b_timer", int'(bus.master_timer), 1);
        adv_to(812);
        chk("ewg_grant_ewped", int'(bus.ew_ped_enable), 1);
        chk("ewg_grant_light", int'(bus.ew_light), 1);
        chk("ewg_grant_timer", int'(bus.master_timer), EXP_WALK);
        ey = 812 + CPS * EXP_WALK;
        adv_to(ey - 1);
        chk("ewg_last_ewped", int'(bus.ew_ped_enable), 1);
        chk("ewg_last_timer", int'(bus.master_timer), 1);
        adv_to(ey);
        chk("ewy_ewped", int'(bus.ew_ped_enable), 0);
        chk("ewy_light", int'(bus.ew_light), 2);
        chk("ewy_timer", int'(bus.master_timer), 5);
        g1 = ey + 28;
        adv_to(g1);
        chk("nsg_after_nsped", int'(bus.ns_ped_enable), 0);
        chk("nsg_after_timer", int'(bus.master_timer), 60);
        chk("nsg_after_light", int'(bus.ns_light), 1);

        // Press exactly in the cycle NS_GREEN is entered.
        e2 = g1 + 268;
        g2 = e2 + 268;
        adv_to(e2);
        chk("ewg_nogrant_ewped", int'(bus.ew_ped_enable), 0);
        adv_to(g2 - 1);
        bus.ped_request = 1'b1;
        step();
        bus.ped_request = 1'b0;
        chk("entry_press_nsped", int'(bus.ns_ped_enable), 1);
        chk("entry_press_timer", int'(bus.master_timer), EXP_WALK);
        chk("entry_press_light", int'(bus.ns_light), 1);
        e3 = g2 + CPS * EXP_WALK + 28;
        adv_to(e3);
        chk("no_carry_ewped", int'(bus.ew_ped_enable), 0);
        chk("no_carry_timer", int'(bus.master_timer), 60);
        chk("no_carry_light", int'(bus.ew_light), 1);

        // Reset mid EW_GREEN with a request pending.
        adv_to(e3 + 40);
        bus.ped_request = 1'b1;
        step();
        bus.ped_request = 1'b0;
        adv_to(e3 + 80);
        reset = 1'b1;
        step();
        chk_all("midrst", '{0, 2, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0});
        reset  = 1'b0;
        edge_n = 0;
        adv_to(3);
        chk("rst_tick3", int'(bus.sec_tick), 1);
        adv_to(8);
        chk("rst_nsg_nsped", int'(bus.ns_ped_enable), 0);
        chk("rst_nsg_timer", int'(bus.master_timer), 60);
        adv_to(276);
        chk("rst_ewg_ewped", int'(bus.ew_ped_enable), 0);
        chk("rst_ewg_timer", int'(bus.master_timer), 60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
